// File: rtl/wb_stage_if.sv
// Bundles the writeback stage's pipeline, regfile, forwarding and trace
// signals so the stage and its neighbours connect through a single port.
interface wb_stage_if #(
    parameter int MS_TO_WS_BUS_WD = 102,
    parameter int WS_TO_RF_BUS_WD = 38,
    parameter int CNT_WD          = 32
);
    logic                       flush;
    logic [5:0]                 stall;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus;
    logic [WS_TO_RF_BUS_WD-1:0] ws_to_es_bus;
    logic                       stallreq_ws;
    logic                       trace_valid;
    logic                       trace_ready;
    logic [31:0]                trace_pc;
    logic [31:0]                trace_inst;
    logic [3:0]                 trace_rf_we;
    logic [4:0]                 trace_rf_wnum;
    logic [31:0]                trace_rf_wdata;
    logic [CNT_WD-1:0]          inst_retired;

    // Pipeline / stall controller / trace consumer side
    modport master (
        output flush, stall, ms_to_ws_bus, trace_ready,
        input  ws_to_rf_bus, ws_to_es_bus, stallreq_ws, trace_valid, trace_pc,
               trace_inst, trace_rf_we, trace_rf_wnum, trace_rf_wdata, inst_retired
    );

    // Writeback stage side
    modport slave (
        input  flush, stall, ms_to_ws_bus, trace_ready,
        output ws_to_rf_bus, ws_to_es_bus, stallreq_ws, trace_valid, trace_pc,
               trace_inst, trace_rf_we, trace_rf_wnum, trace_rf_wdata, inst_retired
    );
endinterface

// File: rtl/wb_stage.sv
// LA32 writeback stage: holds the retiring instruction, writes the regfile
// exactly once per instruction, forwards its result, pushes it into a small
// trace FIFO for the difftest port and counts retirements. Requests a stall
// when the trace FIFO cannot take the instruction in WB.
module wb_stage #(
    parameter int MS_TO_WS_BUS_WD = 102,
    parameter int WS_TO_RF_BUS_WD = 38,
    parameter int TRACE_DEPTH     = 4,
    parameter int CNT_WD          = 32
) (
    input  logic      clk,
    input  logic      reset,
    wb_stage_if.slave wb
);
    localparam int PTR_WD   = $clog2(TRACE_DEPTH);
    // Trace entry layout: {pc[31:0], inst[31:0], we, wnum[4:0], wdata[31:0]}
    localparam int ENTRY_WD = 102;

    // WB register fields: {reg_we, dest, result, pc, inst}
    logic [MS_TO_WS_BUS_WD-1:0] ws_bus_reg;
    logic                       pending_reg;
    logic                       ws_reg_we;
    logic [4:0]                 ws_dest;
    logic [31:0]                ws_result;
    logic [31:0]                ws_pc;
    logic [31:0]                ws_inst;
    logic                       ws_valid;
    logic                       dest_nz;
    logic [31:0]                ms_pc;

    assign {ws_reg_we, ws_dest, ws_result, ws_pc, ws_inst} = ws_bus_reg;
    assign ws_valid = |ws_pc;
    assign dest_nz  = (ws_dest != 5'd0);
    assign ms_pc    = wb.ms_to_ws_bus[63:32];

    // Only the WB hold bit and the downstream bit matter here
    logic unused_stall;
    assign unused_stall = ^wb.stall[3:0];

    // Trace FIFO state
    logic [PTR_WD-1:0]   wr_ptr_reg;
    logic [PTR_WD-1:0]   rd_ptr_reg;
    logic [PTR_WD:0]     cnt_reg;
    logic [ENTRY_WD-1:0] entry_reg [TRACE_DEPTH];
    logic [CNT_WD-1:0]   retired_reg;

    logic                fifo_empty;
    logic                fifo_full;
    logic                pop;
    logic                commit;
    logic [ENTRY_WD-1:0] push_entry;
    logic [ENTRY_WD-1:0] head_entry;

    // Depth is a power of two, so the count MSB alone marks "full"
    assign fifo_empty = (cnt_reg == '0);
    assign fifo_full  = cnt_reg[PTR_WD];
    assign pop        = !fifo_empty && wb.trace_ready;
    // A full FIFO still accepts the commit when its head leaves in the same cycle
    assign commit     = pending_reg && (!fifo_full || pop);

    assign push_entry = {ws_pc, ws_inst, ws_reg_we && dest_nz, ws_dest, ws_result};
    assign head_entry = fifo_empty ? '0 : entry_reg[rd_ptr_reg];

    // Regfile write fires only in the commit cycle, so a held WB register never rewrites
    logic                       rf_we;
    logic [WS_TO_RF_BUS_WD-1:0] rf_bus;
    assign rf_we  = commit && ws_reg_we && dest_nz;
    assign rf_bus = {rf_we, rf_we ? ws_dest : 5'd0, rf_we ? ws_result : 32'd0};

    assign wb.ws_to_rf_bus   = rf_bus;
    assign wb.ws_to_es_bus   = {ws_reg_we && ws_valid && dest_nz, ws_dest, ws_result};
    assign wb.stallreq_ws    = pending_reg && !commit;
    assign wb.trace_valid    = !fifo_empty;
    assign wb.trace_pc       = head_entry[101:70];
    assign wb.trace_inst     = head_entry[69:38];
    assign wb.trace_rf_we    = {4{head_entry[37]}};
    assign wb.trace_rf_wnum  = head_entry[36:32];
    assign wb.trace_rf_wdata = head_entry[31:0];
    assign wb.inst_retired   = retired_reg;

    // WB register and pending flag: flush, bubble, capture, or hold until commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_bus_reg  <= '0;
            pending_reg <= 1'b0;
        end else if (wb.flush) begin
            ws_bus_reg  <= '0;
            pending_reg <= 1'b0;
        end else if (wb.stall[4] && !wb.stall[5]) begin
            ws_bus_reg  <= '0;
            pending_reg <= 1'b0;
        end else if (!wb.stall[4]) begin
            ws_bus_reg  <= wb.ms_to_ws_bus;
            pending_reg <= |ms_pc;
        end else if (commit) begin
            pending_reg <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (commit) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (commit && !pop) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else if (!commit && pop) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    // One storage register per FIFO slot, written when the write pointer selects it
    for (genvar gi = 0; gi < TRACE_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                entry_reg[gi] <= '0;
            end else if (commit && (wr_ptr_reg == PTR_WD'(gi))) begin
                entry_reg[gi] <= push_entry;
            end
        end
    end

    // Retirement counter, wraps naturally at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_reg <= '0;
        end else if (commit) begin
            retired_reg <= retired_reg + 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: single retire, FIFO full/stall, same-cycle
// pop at full, dest=0, held WB, flush of a pending instruction, async reset
// and counter wrap (on a narrow-counter instance).
module tb_wb_stage;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   exp_ret;

    wb_stage_if w ();
    wb_stage_if #(.CNT_WD(4)) w4 ();

    wb_stage dut (.clk(clk), .reset(reset), .wb(w.slave));
    wb_stage #(.CNT_WD(4)) dut4 (.clk(clk), .reset(reset), .wb(w4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [101:0] mk(input logic we, input logic [4:0] d,
                                        input logic [31:0] r, input logic [31:0] p,
                                        input logic [31:0] i);
        return {we, d, r, p, i};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        w.flush = 1'b0; w.stall = 6'd0; w.ms_to_ws_bus = '0; w.trace_ready = 1'b0;
        w4.flush = 1'b0; w4.stall = 6'd0; w4.ms_to_ws_bus = '0; w4.trace_ready = 1'b1;
        exp_ret = 0;
        repeat (2) step();
        checks++; if (w.ws_to_rf_bus !== 38'd0) begin failures++; $display("FAIL reset_rf: got %h expected 0", w.ws_to_rf_bus); end
        checks++; if (w.ws_to_es_bus !== 38'd0) begin failures++; $display("FAIL reset_es: got %h expected 0", w.ws_to_es_bus); end
        checks++; if (w.stallreq_ws !== 1'b0) begin failures++; $display("FAIL reset_stallreq: got %b expected 0", w.stallreq_ws); end
        checks++; if (w.trace_valid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b expected 0", w.trace_valid); end
        checks++; if (w.trace_pc !== 32'd0) begin failures++; $display("FAIL reset_tpc: got %h expected 0", w.trace_pc); end
        checks++; if (w.inst_retired !== 32'd0) begin failures++; $display("FAIL reset_cnt: got %h expected 0", w.inst_retired); end
        reset = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_single();
        w.trace_ready = 1'b1;
        w.ms_to_ws_bus = mk(1'b1, 5'd4, 32'd5, 32'h1c000000, 32'h00100004);
        step();
        w.ms_to_ws_bus = '0;
        #1;
        checks++; if (w.ws_to_rf_bus !== {1'b1, 5'd4, 32'd5}) begin failures++; $display("FAIL single_rf: got %h expected %h", w.ws_to_rf_bus, {1'b1, 5'd4, 32'd5}); end
        checks++; if (w.ws_to_es_bus !== {1'b1, 5'd4, 32'd5}) begin failures++; $display("FAIL single_es: got %h expected %h", w.ws_to_es_bus, {1'b1, 5'd4, 32'd5}); end
        checks++; if (w.stallreq_ws !== 1'b0) begin failures++; $display("FAIL single_stallreq: got %b expected 0", w.stallreq_ws); end
        step();
        exp_ret = exp_ret + 1;
        checks++; if (w.ws_to_rf_bus !== 38'd0) begin failures++; $display("FAIL single_rf_once: got %h expected 0", w.ws_to_rf_bus); end
        checks++; if (w.trace_valid !== 1'b1) begin failures++; $display("FAIL single_tvalid: got %b expected 1", w.trace_valid); end
        checks++; if (w.trace_pc !== 32'h1c000000) begin failures++; $display("FAIL single_tpc: got %h expected 1c000000", w.trace_pc); end
        checks++; if (w.trace_inst !== 32'h00100004) begin failures++; $display("FAIL single_tinst: got %h expected 00100004", w.trace_inst); end
        checks++; if (w.trace_rf_we !== 4'hf) begin failures++; $display("FAIL single_twe: got %h expected f", w.trace_rf_we); end
        checks++; if (w.trace_rf_wnum !== 5'd4) begin failures++; $display("FAIL single_twnum: got %0d expected 4", w.trace_rf_wnum); end
        checks++; if (w.trace_rf_wdata !== 32'd5) begin failures++; $display("FAIL single_twdata: got %h expected 5", w.trace_rf_wdata); end
        checks++; if (w.inst_retired !== 32'(exp_ret)) begin failures++; $display("FAIL single_cnt: got %0d expected %0d", w.inst_retired, exp_ret); end
        step();
        checks++; if (w.trace_valid !== 1'b0) begin failures++; $display("FAIL single_popped: got %b expected 0", w.trace_valid); end
        $display("test_single done");
    endtask

    task automatic test_fifo_full();
        logic [31:0] pc;
        w.trace_ready = 1'b0;
        w.stall = 6'd0;
        for (int k = 0; k < 5; k++) begin
            w.ms_to_ws_bus = mk(1'b1, 5'(k + 1), 32'(256 + k), 32'h1c000100 + 32'(4 * k), 32'h02800000 + 32'(k));
            step();
            if (k < 4) begin
                checks++; if (w.ws_to_rf_bus !== {1'b1, 5'(k + 1), 32'(256 + k)}) begin failures++; $display("FAIL full_rf%0d: got %h expected %h", k, w.ws_to_rf_bus, {1'b1, 5'(k + 1), 32'(256 + k)}); end
                checks++; if (w.stallreq_ws !== 1'b0) begin failures++; $display("FAIL full_nostall%0d: got %b expected 0", k, w.stallreq_ws); end
            end else begin
                checks++; if (w.stallreq_ws !== 1'b1) begin failures++; $display("FAIL full_stallreq: got %b expected 1", w.stallreq_ws); end
                checks++; if (w.ws_to_rf_bus !== 38'd0) begin failures++; $display("FAIL full_norf: got %h expected 0", w.ws_to_rf_bus); end
            end
        end
        w.stall = 6'b110000;
        w.ms_to_ws_bus = '0;
        step();
        exp_ret = exp_ret + 4;
        checks++; if (w.stallreq_ws !== 1'b1) begin failures++; $display("FAIL full_stall_held: got %b expected 1", w.stallreq_ws); end
        checks++; if (w.ws_to_rf_bus !== 38'd0) begin failures++; $display("FAIL full_norf_held: got %h expected 0", w.ws_to_rf_bus); end
        checks++; if (w.trace_pc !== 32'h1c000100) begin failures++; $display("FAIL full_head: got %h expected 1c000100", w.trace_pc); end
        checks++; if (w.inst_retired !== 32'(exp_ret)) begin failures++; $display("FAIL full_cnt: got %0d expected %0d", w.inst_retired, exp_ret); end
        // Pop while full: the pending instruction commits in this same cycle
        w.trace_ready = 1'b1;
        #1;
        checks++; if (w.stallreq_ws !== 1'b0) begin failures++; $display("FAIL popfull_stallreq: got %b expected 0", w.stallreq_ws); end
        checks++; if (w.ws_to_rf_bus !== {1'b1, 5'd5, 32'd260}) begin failures++; $display("FAIL popfull_rf: got %h expected %h", w.ws_to_rf_bus, {1'b1, 5'd5, 32'd260}); end
        step();
        exp_ret = exp_ret + 1;
        checks++; if (w.inst_retired !== 32'(exp_ret)) begin failures++; $display("FAIL popfull_cnt: got %0d expected %0d", w.inst_retired, exp_ret); end
        w.stall = 6'd0;
        for (int k = 1; k < 5; k++) begin
            pc = 32'h1c000100 + 32'(4 * k);
            checks++; if (w.trace_pc !== pc) begin failures++; $display("FAIL drain_pc%0d: got %h expected %h", k, w.trace_pc, pc); end
            step();
        end
        checks++; if (w.trace_valid !== 1'b0) begin failures++; $display("FAIL drain_empty: got %b expected 0", w.trace_valid); end
        $display("test_fifo_full done");
    endtask

    task automatic test_dest_zero();
        w.trace_ready = 1'b1;
        w.stall = 6'd0;
        w.ms_to_ws_bus = mk(1'b1, 5'd0, 32'hdead, 32'h1c000200, 32'h02800400);
        step();
        w.ms_to_ws_bus = '0;
        #1;
        checks++; if (w.ws_to_rf_bus !== 38'd0) begin failures++; $display("FAIL dz_rf: got %h expected 0", w.ws_to_rf_bus); end
        checks++; if (w.ws_to_es_bus !== {1'b0, 5'd0, 32'hdead}) begin failures++; $display("FAIL dz_es: got %h expected %h", w.ws_to_es_bus, {1'b0, 5'd0, 32'hdead}); end
        step();
        exp_ret = exp_ret + 1;
        checks++; if (w.trace_valid !== 1'b1) begin failures++; $display("FAIL dz_tvalid: got %b expected 1", w.trace_valid); end
        checks++; if (w.trace_pc !== 32'h1c000200) begin failures++; $display("FAIL dz_tpc: got %h expected 1c000200", w.trace_pc); end
        checks++; if (w.trace_rf_we !== 4'h0) begin failures++; $display("FAIL dz_twe: got %h expected 0", w.trace_rf_we); end
        checks++; if (w.inst_retired !== 32'(exp_ret)) begin failures++; $display("FAIL dz_cnt: got %0d expected %0d", w.inst_retired, exp_ret); end
        step();
        $display("test_dest_zero done");
    endtask

    task automatic test_hold();
        w.trace_ready = 1'b1;
        w.stall = 6'd0;
        w.ms_to_ws_bus = mk(1'b1, 5'd7, 32'h77, 32'h1c000300, 32'h02800500);
        step();
        w.ms_to_ws_bus = '0;
        w.stall = 6'b110000;
        #1;
        checks++; if (w.ws_to_rf_bus !== {1'b1, 5'd7, 32'h77}) begin failures++; $display("FAIL hold_rf: got %h expected %h", w.ws_to_rf_bus, {1'b1, 5'd7, 32'h77}); end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (w.ws_to_rf_bus !== 38'd0) begin failures++; $display("FAIL hold_norf%0d: got %h expected 0", c, w.ws_to_rf_bus); end
            checks++; if (w.ws_to_es_bus !== {1'b1, 5'd7, 32'h77}) begin failures++; $display("FAIL hold_es%0d: got %h expected %h", c, w.ws_to_es_bus, {1'b1, 5'd7, 32'h77}); end
        end
        exp_ret = exp_ret + 1;
        checks++; if (w.inst_retired !== 32'(exp_ret)) begin failures++; $display("FAIL hold_cnt: got %0d expected %0d", w.inst_retired, exp_ret); end
        checks++; if (w.trace_valid !== 1'b0) begin failures++; $display("FAIL hold_onepush: got %b expected 0", w.trace_valid); end
        w.stall = 6'd0;
        repeat (2) step();
        $display("test_hold done");
    endtask

    task automatic fill_fifo(input logic [31:0] base);
        w.stall = 6'd0;
        w.trace_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w.ms_to_ws_bus = mk(1'b1, 5'(k + 1), 32'(k), base + 32'(4 * k), 32'(k));
            step();
        end
        w.ms_to_ws_bus = '0;
        step();
    endtask

    task automatic test_flush();
        logic [31:0] pc;
        fill_fifo(32'h1c000400);
        exp_ret = exp_ret + 4;
        w.ms_to_ws_bus = mk(1'b1, 5'd9, 32'h99, 32'h1c000500, 32'h02800600);
        step();
        w.ms_to_ws_bus = '0;
        w.stall = 6'b110000;
        w.flush = 1'b1;
        #1;
        checks++; if (w.stallreq_ws !== 1'b1) begin failures++; $display("FAIL flush_stallreq: got %b expected 1", w.stallreq_ws); end
        checks++; if (w.ws_to_rf_bus !== 38'd0) begin failures++; $display("FAIL flush_norf: got %h expected 0", w.ws_to_rf_bus); end
        step();
        w.flush = 1'b0;
        w.stall = 6'd0;
        #1;
        checks++; if (w.ws_to_es_bus !== 38'd0) begin failures++; $display("FAIL flush_es: got %h expected 0", w.ws_to_es_bus); end
        checks++; if (w.stallreq_ws !== 1'b0) begin failures++; $display("FAIL flush_clear: got %b expected 0", w.stallreq_ws); end
        checks++; if (w.inst_retired !== 32'(exp_ret)) begin failures++; $display("FAIL flush_cnt: got %0d expected %0d", w.inst_retired, exp_ret); end
        w.trace_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pc = 32'h1c000400 + 32'(4 * k);
            checks++; if (w.trace_pc !== pc) begin failures++; $display("FAIL flush_drain%0d: got %h expected %h", k, w.trace_pc, pc); end
            step();
        end
        checks++; if (w.trace_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped: got %b expected 0", w.trace_valid); end
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        w.trace_ready = 1'b0;
        w.stall = 6'd0;
        w.ms_to_ws_bus = mk(1'b1, 5'd2, 32'h22, 32'h1c000600, 32'h1);
        step();
        w.ms_to_ws_bus = mk(1'b1, 5'd3, 32'h33, 32'h1c000604, 32'h2);
        step();
        w.ms_to_ws_bus = '0;
        step();
        w.trace_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        exp_ret = 0;
        checks++; if (w.trace_valid !== 1'b0) begin failures++; $display("FAIL areset_tvalid: got %b expected 0", w.trace_valid); end
        checks++; if (w.trace_pc !== 32'd0) begin failures++; $display("FAIL areset_tpc: got %h expected 0", w.trace_pc); end
        checks++; if (w.trace_rf_wdata !== 32'd0) begin failures++; $display("FAIL areset_twdata: got %h expected 0", w.trace_rf_wdata); end
        checks++; if (w.inst_retired !== 32'd0) begin failures++; $display("FAIL areset_cnt: got %0d expected 0", w.inst_retired); end
        checks++; if (w.ws_to_es_bus !== 38'd0) begin failures++; $display("FAIL areset_es: got %h expected 0", w.ws_to_es_bus); end
        step();
        reset = 1'b0;
        step();
        $display("test_async_reset done");
    endtask

    task automatic test_wrap();
        w4.stall = 6'd0;
        w4.trace_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            w4.ms_to_ws_bus = mk(1'b1, 5'd3, 32'(k), 32'h1c001000 + 32'(4 * k), 32'(k));
            step();
        end
        checks++; if (w4.inst_retired !== 4'hf) begin failures++; $display("FAIL wrap_allones: got %h expected f", w4.inst_retired); end
        w4.ms_to_ws_bus = '0;
        step();
        checks++; if (w4.inst_retired !== 4'h0) begin failures++; $display("FAIL wrap_zero: got %h expected 0", w4.inst_retired); end
        $display("test_wrap done");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_fifo_full();
        test_dest_zero();
        test_hold();
        test_flush();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
